// File: rtl/slv_guard_rst_ctrl.sv
// ---------------------------------------------------------------------------
// slv_guard_rst_ctrl
//
// Responder side of the guard reset handshake. On a reset request from the
// guard it isolates the subordinate, waits a bounded time for in-flight beats
// to drain, drives a timed active-low reset pulse to the subordinate, waits a
// settle period and then acknowledges completion back to the guard.
//
// Ports:
//   clk_i            clock
//   rst_ni           synchronous active-low reset
//   rst_req_i        reset request from guard (level, held until acknowledged)
//   busy_i           subordinate still has outstanding handshakes
//   drain_cycles_i   max drain duration, 0 = skip drain (single cycle)
//   assert_cycles_i  subordinate reset pulse length, 0 treated as 1
//   settle_cycles_i  post-reset wait, 0 = single pass-through cycle
//   isolate_o        gate manager/subordinate handshakes
//   sub_rst_no       active-low reset to the subordinate
//   rst_stat_o       reset sequence complete (to guard reset_clear_i)
//   drain_timeout_o  one-cycle pulse when drain ended by timeout with busy_i high
//   state_o          current FSM state (IDLE=0 DRAIN=1 ASSERT=2 SETTLE=3 ACK=4)
//   rst_evt_cnt_o    saturating count of completed reset sequences
//
// Build option:
//   SLV_GUARD_RST_CTRL_EVT_CNT_EN  when defined, rst_evt_cnt_o is a saturating
//                                  counter; otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module slv_guard_rst_ctrl #(
    parameter int unsigned CntWidth    = 10,
    parameter int unsigned EvtCntWidth = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   rst_req_i,
    input  logic                   busy_i,
    input  logic [CntWidth-1:0]    drain_cycles_i,
    input  logic [CntWidth-1:0]    assert_cycles_i,
    input  logic [CntWidth-1:0]    settle_cycles_i,
    output logic                   isolate_o,
    output logic                   sub_rst_no,
    output logic                   rst_stat_o,
    output logic                   drain_timeout_o,
    output logic [2:0]             state_o,
    output logic [EvtCntWidth-1:0] rst_evt_cnt_o
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StDrain  = 3'd1,
        StAssert = 3'd2,
        StSettle = 3'd3,
        StAck    = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [CntWidth-1:0] drain_sh_q, drain_sh_d;
    logic [CntWidth-1:0] assert_sh_q, assert_sh_d;
    logic [CntWidth-1:0] settle_sh_q, settle_sh_d;
    logic                timeout_q, timeout_d;
    logic                isolate_q, sub_rst_n_q, rst_stat_q;
    logic                evt_inc;

    // Terminal count values; only meaningful when the shadow is non-zero,
    // zero cases are handled explicitly in the next-state logic.
    logic [CntWidth-1:0] drain_last, assert_last, settle_last;

    assign drain_last  = drain_sh_q - CntWidth'(1);
    assign settle_last = settle_sh_q - CntWidth'(1);
    assign assert_last = (assert_sh_q == '0) ? '0 : (assert_sh_q - CntWidth'(1));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        drain_sh_d  = drain_sh_q;
        assert_sh_d = assert_sh_q;
        settle_sh_d = settle_sh_q;
        timeout_d   = 1'b0;
        evt_inc     = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (rst_req_i) begin
                    state_d     = StDrain;
                    // Durations are frozen for the whole sequence.
                    drain_sh_d  = drain_cycles_i;
                    assert_sh_d = assert_cycles_i;
                    settle_sh_d = settle_cycles_i;
                end
            end

            StDrain: begin
                if (!busy_i || (drain_sh_q == '0) || (cnt_q == drain_last)) begin
                    state_d   = StAssert;
                    cnt_d     = '0;
                    // Leaving with busy_i still high means the budget ran out.
                    timeout_d = busy_i;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end

            StAssert: begin
                if (cnt_q == assert_last) begin
                    state_d = StSettle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end

            StSettle: begin
                if ((settle_sh_q == '0) || (cnt_q == settle_last)) begin
                    state_d = StAck;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end

            StAck: begin
                if (!rst_req_i) begin
                    state_d = StIdle;
                    evt_inc = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers. Outputs are decoded from the next state
    // so they are flop outputs that track the current state exactly.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            drain_sh_q  <= '0;
            assert_sh_q <= '0;
            settle_sh_q <= '0;
            timeout_q   <= 1'b0;
            isolate_q   <= 1'b0;
            sub_rst_n_q <= 1'b1;
            rst_stat_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drain_sh_q  <= drain_sh_d;
            assert_sh_q <= assert_sh_d;
            settle_sh_q <= settle_sh_d;
            timeout_q   <= timeout_d;
            isolate_q   <= (state_d != StIdle);
            sub_rst_n_q <= (state_d != StAssert);
            rst_stat_q  <= (state_d == StAck);
        end
    end

    assign isolate_o       = isolate_q;
    assign sub_rst_no      = sub_rst_n_q;
    assign rst_stat_o      = rst_stat_q;
    assign drain_timeout_o = timeout_q;
    assign state_o         = state_q;

    // ------------------------------------------------------------------
    // Completed-sequence event counter
    // ------------------------------------------------------------------
`ifdef SLV_GUARD_RST_CTRL_EVT_CNT_EN
    logic [EvtCntWidth-1:0] evt_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            evt_cnt_q <= '0;
        end else if (evt_inc && (evt_cnt_q != '1)) begin
            evt_cnt_q <= evt_cnt_q + EvtCntWidth'(1);
        end
    end

    assign rst_evt_cnt_o = evt_cnt_q;
`else
    logic unused_evt_inc;
    assign unused_evt_inc = evt_inc;
    assign rst_evt_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_slv_guard_rst_ctrl
//
// Directed self-checking bench for slv_guard_rst_ctrl. "Cycle n" is the
// sample point #1 after the n-th rising edge following the request.
// Observed vector: {state_o, isolate_o, sub_rst_no, rst_stat_o, drain_timeout_o}.
// ---------------------------------------------------------------------------
module tb_slv_guard_rst_ctrl;

    localparam int unsigned CntW = 10;
    localparam int unsigned EvtW = 2;

    logic            clk;
    logic            rst_n;
    logic            rst_req;
    logic            busy;
    logic [CntW-1:0] drain_cycles;
    logic [CntW-1:0] assert_cycles;
    logic [CntW-1:0] settle_cycles;
    logic            isolate;
    logic            sub_rst_n;
    logic            rst_stat;
    logic            drain_timeout;
    logic [2:0]      state;
    logic [EvtW-1:0] rst_evt_cnt;

    int checks = 0;
    int errors = 0;
    int seq_done = 0;  // completed sequences since last reset

    slv_guard_rst_ctrl #(
        .CntWidth    (CntW),
        .EvtCntWidth (EvtW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .rst_req_i       (rst_req),
        .busy_i          (busy),
        .drain_cycles_i  (drain_cycles),
        .assert_cycles_i (assert_cycles),
        .settle_cycles_i (settle_cycles),
        .isolate_o       (isolate),
        .sub_rst_no      (sub_rst_n),
        .rst_stat_o      (rst_stat),
        .drain_timeout_o (drain_timeout),
        .state_o         (state),
        .rst_evt_cnt_o   (rst_evt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected output vector for a given state and timeout pulse.
    function automatic logic [6:0] exp_vec(input logic [2:0] st, input logic to);
        return {st, (st != 3'd0), (st != 3'd2), (st == 3'd4), to};
    endfunction

    function automatic logic [EvtW-1:0] exp_evt(input int n);
`ifdef SLV_GUARD_RST_CTRL_EVT_CNT_EN
        if (n >= (1 << EvtW) - 1) return '1;
        return n[EvtW-1:0];
`else
        return '0;
`endif
    endfunction

    function automatic logic [6:0] obs_vec();
        return {state, isolate, sub_rst_n, rst_stat, drain_timeout};
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        seq_done = 0;
        checks++;
        if (obs_vec() !== exp_vec(3'd0, 1'b0)) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b", obs_vec(), exp_vec(3'd0, 1'b0));
        end
        checks++;
        if (rst_evt_cnt !== '0) begin
            errors++;
            $display("FAIL reset_evt_cnt: got %0d want 0", rst_evt_cnt);
        end
        tick;
        checks++;
        if (obs_vec() !== exp_vec(3'd0, 1'b0)) begin
            errors++;
            $display("FAIL reset_idle_hold: got %b want %b", obs_vec(), exp_vec(3'd0, 1'b0));
        end
    endtask

    task automatic test_idle_quiesce;
        logic [2:0] st;
        drain_cycles = 10'd8; assert_cycles = 10'd4; settle_cycles = 10'd2;
        busy = 1'b0;
        rst_req = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            if (c == 11) rst_req = 1'b0;
            tick;
            st = (c == 1) ? 3'd1 : (c <= 5) ? 3'd2 : (c <= 7) ? 3'd3 : (c <= 10) ? 3'd4 : 3'd0;
            checks++;
            if (obs_vec() !== exp_vec(st, 1'b0)) begin
                errors++;
                $display("FAIL idle_quiesce cycle %0d: got %b want %b",
                         c, obs_vec(), exp_vec(st, 1'b0));
            end
        end
        seq_done++;
        checks++;
        if (rst_evt_cnt !== exp_evt(seq_done)) begin
            errors++;
            $display("FAIL idle_quiesce_evt: got %0d want %0d", rst_evt_cnt, exp_evt(seq_done));
        end
    endtask

    task automatic test_drain_timeout;
        logic [2:0] st;
        int pulses;
        pulses = 0;
        drain_cycles = 10'd5; assert_cycles = 10'd3; settle_cycles = 10'd1;
        busy = 1'b1;
        rst_req = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            if (c == 11) rst_req = 1'b0;
            tick;
            st = (c <= 5) ? 3'd1 : (c <= 8) ? 3'd2 : (c == 9) ? 3'd3 : (c == 10) ? 3'd4 : 3'd0;
            if (drain_timeout) pulses++;
            checks++;
            if (obs_vec() !== exp_vec(st, c == 6)) begin
                errors++;
                $display("FAIL drain_timeout cycle %0d: got %b want %b",
                         c, obs_vec(), exp_vec(st, c == 6));
            end
        end
        busy = 1'b0;
        seq_done++;
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL drain_timeout_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_early_drain;
        logic [2:0] st;
        drain_cycles = 10'd100; assert_cycles = 10'd2; settle_cycles = 10'd0;
        busy = 1'b1;
        rst_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            if (c == 4) busy = 1'b0;
            if (c == 8) rst_req = 1'b0;
            tick;
            st = (c <= 3) ? 3'd1 : (c <= 5) ? 3'd2 : (c == 6) ? 3'd3 : (c == 7) ? 3'd4 : 3'd0;
            checks++;
            if (obs_vec() !== exp_vec(st, 1'b0)) begin
                errors++;
                $display("FAIL early_drain cycle %0d: got %b want %b",
                         c, obs_vec(), exp_vec(st, 1'b0));
            end
        end
        seq_done++;
    endtask

    task automatic test_zero_durations;
        logic [2:0] st;
        drain_cycles = '0; assert_cycles = '0; settle_cycles = '0;
        busy = 1'b0;
        rst_req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) rst_req = 1'b0;
            tick;
            st = (c <= 4) ? c[2:0] : 3'd0;
            checks++;
            if (obs_vec() !== exp_vec(st, 1'b0)) begin
                errors++;
                $display("FAIL zero_durations cycle %0d: got %b want %b",
                         c, obs_vec(), exp_vec(st, 1'b0));
            end
        end
        seq_done++;
        checks++;
        if (rst_evt_cnt !== exp_evt(seq_done)) begin
            errors++;
            $display("FAIL zero_durations_evt: got %0d want %0d", rst_evt_cnt, exp_evt(seq_done));
        end
    endtask

    task automatic test_mid_change;
        logic [2:0] st;
        drain_cycles = '0; assert_cycles = 10'd4; settle_cycles = '0;
        busy = 1'b0;
        rst_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            if (c == 3) begin
                // Already in ASSERT: these must not affect the running sequence.
                assert_cycles = 10'd1; drain_cycles = 10'd7; settle_cycles = 10'd9;
            end
            if (c == 8) rst_req = 1'b0;
            tick;
            st = (c == 1) ? 3'd1 : (c <= 5) ? 3'd2 : (c == 6) ? 3'd3 : (c == 7) ? 3'd4 : 3'd0;
            checks++;
            if (obs_vec() !== exp_vec(st, 1'b0)) begin
                errors++;
                $display("FAIL mid_change cycle %0d: got %b want %b",
                         c, obs_vec(), exp_vec(st, 1'b0));
            end
        end
        seq_done++;
        checks++;
        if (rst_evt_cnt !== exp_evt(seq_done)) begin
            errors++;
            $display("FAIL mid_change_evt: got %0d want %0d", rst_evt_cnt, exp_evt(seq_done));
        end
    endtask

    task automatic test_reset_mid_assert;
        drain_cycles = '0; assert_cycles = 10'd6; settle_cycles = '0;
        busy = 1'b0;
        rst_req = 1'b1;
        tick;
        tick;
        checks++;
        if (obs_vec() !== exp_vec(3'd2, 1'b0)) begin
            errors++;
            $display("FAIL reset_mid_in_assert: got %b want %b", obs_vec(), exp_vec(3'd2, 1'b0));
        end
        rst_n = 1'b0;
        tick;
        seq_done = 0;
        checks++;
        if (obs_vec() !== exp_vec(3'd0, 1'b0)) begin
            errors++;
            $display("FAIL reset_mid_forced: got %b want %b", obs_vec(), exp_vec(3'd0, 1'b0));
        end
        checks++;
        if (rst_evt_cnt !== '0) begin
            errors++;
            $display("FAIL reset_mid_evt: got %0d want 0", rst_evt_cnt);
        end
        rst_req = 1'b0;
        rst_n   = 1'b1;
        tick;
        checks++;
        if (obs_vec() !== exp_vec(3'd0, 1'b0)) begin
            errors++;
            $display("FAIL reset_mid_release: got %b want %b", obs_vec(), exp_vec(3'd0, 1'b0));
        end
    endtask

    task automatic test_back_to_back;
        drain_cycles = '0; assert_cycles = '0; settle_cycles = '0;
        busy = 1'b0;
        for (int s = 0; s < 5; s++) begin
            rst_req = 1'b1;
            repeat (4) tick;
            checks++;
            if (obs_vec() !== exp_vec(3'd4, 1'b0)) begin
                errors++;
                $display("FAIL back_to_back_ack seq %0d: got %b want %b",
                         s, obs_vec(), exp_vec(3'd4, 1'b0));
            end
            rst_req = 1'b0;
            tick;
            seq_done++;
            checks++;
            if (rst_evt_cnt !== exp_evt(seq_done)) begin
                errors++;
                $display("FAIL back_to_back_evt seq %0d: got %0d want %0d",
                         s, rst_evt_cnt, exp_evt(seq_done));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rst_req = 1'b0;
        busy = 1'b0;
        drain_cycles = '0;
        assert_cycles = '0;
        settle_cycles = '0;

        test_reset;
        test_idle_quiesce;
        test_drain_timeout;
        test_early_drain;
        test_zero_durations;
        test_mid_change;
        test_reset_mid_assert;
        test_back_to_back;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
